bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 30 +++
 rtl/bus_arbiter_rr_pick.sv | 39 +++
 rtl/bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the 4-master round-robin bus arbiter:
//   - arb_state_e : 2-bit FSM state encoding (IDLE, GRANTED, BUSY, RELEASE)
//   - NUM_MASTERS / ID_W : master count and grant-index width
//   - DEF_GRANT_TIMEOUT / DEF_TRANS_TIMEOUT : default timeout limits
//   - id_to_onehot : master index -> one-hot grant vector
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

   localparam int NUM_MASTERS       = 4;
   localparam int ID_W              = $clog2(NUM_MASTERS);
   localparam int DEF_GRANT_TIMEOUT = 16;
   localparam int DEF_TRANS_TIMEOUT = 1024;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GRANTED  = 2'd1,
      ST_BUSY     = 2'd2,
      ST_RELEASE  = 2'd3
   } arb_state_e;

   function automatic logic [NUM_MASTERS-1:0] id_to_onehot(input logic [ID_W-1:0] id);
      logic [NUM_MASTERS-1:0] oh;
      oh     = '0;
      oh[id] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin selector. Searches the request vector starting
// at (last_id+1) mod NUM_MASTERS and wrapping upward; the first set bit wins.
// Ports:
//   request_i [NUM_MASTERS-1:0] : per-master request bits
//   last_id_i [ID_W-1:0]        : most recent grantee
//   winner_o  [ID_W-1:0]        : selected master (0 when valid_o is low)
//   valid_o                     : at least one request is pending
// ---------------------------------------------------------------------------
module rr_priority_pick
   import bus_arbiter_pkg::*;
(
   input  logic [NUM_MASTERS-1:0] request_i,
   input  logic [ID_W-1:0]        last_id_i,
   output logic [ID_W-1:0]        winner_o,
   output logic                   valid_o
);

   logic [ID_W-1:0] idx;
   logic            found;

   always_comb begin
      winner_o = '0;
      found    = 1'b0;
      idx      = '0;
      // Offsets 1..NUM_MASTERS: the last grantee is checked last, and the
      // ID_W-bit add wraps naturally modulo NUM_MASTERS.
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         idx = last_id_i + ID_W'(k);
         if (!found && request_i[idx]) begin
            found    = 1'b1;
            winner_o = idx;
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter for 4 bus masters with grant and transaction timeouts.
// Handshake: a master holds bus_request; the arbiter answers with a one-hot
// bus_grant one cycle later; the grantee pulses begin_transaction to claim
// the bus, and end_transaction / bus_error (bus-wide pulses) release it.
// After every ownership the grant is held at zero for one RELEASE cycle.
// Ports:
//   clock, reset (async, active-low)
//   bus_request[3:0], begin_transaction, end_transaction, bus_error
//   bus_grant[3:0]   : registered one-hot grant, zero in IDLE/RELEASE
//   granted_id[1:0]  : current or most recent grantee
//   arb_busy         : state is not IDLE
//   timeout_error    : 1-cycle pulse on grant or watchdog timeout
//   state_dbg        : current FSM state for checkers
// ---------------------------------------------------------------------------
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
   parameter int TRANS_TIMEOUT = DEF_TRANS_TIMEOUT
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] bus_request,
   input  logic                   begin_transaction,
   input  logic                   end_transaction,
   input  logic                   bus_error,
   output logic [NUM_MASTERS-1:0] bus_grant,
   output logic [ID_W-1:0]        granted_id,
   output logic                   arb_busy,
   output logic                   timeout_error,
   output arb_state_e             state_dbg
);

   localparam int MAX_TO = (GRANT_TIMEOUT > TRANS_TIMEOUT) ? GRANT_TIMEOUT : TRANS_TIMEOUT;
   localparam int CNT_W  = $clog2(MAX_TO) + 1;

   // The counter holds the number of cycles already spent in the state, so
   // the limit is hit on the cycle where the count equals limit-1.
   localparam logic [CNT_W-1:0] GRANT_LAST = CNT_W'(GRANT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TRANS_LAST = CNT_W'(TRANS_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   arb_state_e             state_q;
   logic [NUM_MASTERS-1:0] grant_q;
   logic [ID_W-1:0]        gid_q;
   logic [ID_W-1:0]        last_id_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   busy_q;
   logic                   timeout_q;

   logic [ID_W-1:0]        pick_id;
   logic                   pick_valid;

   rr_priority_pick u_pick (
      .request_i (bus_request),
      .last_id_i (last_id_q),
      .winner_o  (pick_id),
      .valid_o   (pick_valid)
   );

   // Saturating increment: the counter parks at all-ones instead of wrapping.
   assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         gid_q     <= '0;
         last_id_q <= ID_W'(NUM_MASTERS - 1);
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pick_valid) begin
                  state_q   <= ST_GRANTED;
                  grant_q   <= id_to_onehot(pick_id);
                  gid_q     <= pick_id;
                  last_id_q <= pick_id;
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
               end
            end
            ST_GRANTED: begin
               // bus_error outranks begin_transaction.
               if (bus_error) begin
                  state_q <= ST_RELEASE;
                  grant_q <= '0;
                  cnt_q   <= '0;
               end else if (begin_transaction) begin
                  state_q <= ST_BUSY;
                  cnt_q   <= '0;
               end else if (!bus_request[gid_q]) begin
                  state_q <= ST_RELEASE;
                  grant_q <= '0;
                  cnt_q   <= '0;
               end else if (cnt_q == GRANT_LAST) begin
                  state_q   <= ST_RELEASE;
                  grant_q   <= '0;
                  cnt_q     <= '0;
                  timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_BUSY: begin
               // A normal end on the watchdog cycle wins: no timeout pulse.
               if (end_transaction || bus_error) begin
                  state_q <= ST_RELEASE;
                  grant_q <= '0;
                  cnt_q   <= '0;
               end else if (cnt_q == TRANS_LAST) begin
                  state_q   <= ST_RELEASE;
                  grant_q   <= '0;
                  cnt_q     <= '0;
                  timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_RELEASE: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               grant_q <= '0;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus_grant     = grant_q;
   assign granted_id    = gid_q;
   assign arb_busy      = busy_q;
   assign timeout_error = timeout_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter: a vector table of single-cycle
// {inputs, expected outputs} rows followed by hand-written multi-cycle
// sequences for round-robin order, grant timeout, watchdog timeout and
// asynchronous reset.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic                   clock = 1'b0;
   logic                   reset = 1'b0;
   logic [NUM_MASTERS-1:0] bus_request = '0;
   logic                   begin_transaction = 1'b0;
   logic                   end_transaction = 1'b0;
   logic                   bus_error = 1'b0;
   logic [NUM_MASTERS-1:0] bus_grant;
   logic [ID_W-1:0]        granted_id;
   logic                   arb_busy;
   logic                   timeout_error;
   arb_state_e             state_dbg;

   always #5 clock = ~clock;

   bus_arbiter dut (
      .clock             (clock),
      .reset             (reset),
      .bus_request       (bus_request),
      .begin_transaction (begin_transaction),
      .end_transaction   (end_transaction),
      .bus_error         (bus_error),
      .bus_grant         (bus_grant),
      .granted_id        (granted_id),
      .arb_busy          (arb_busy),
      .timeout_error     (timeout_error),
      .state_dbg         (state_dbg)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [ID_W-1:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [3:0] req, input logic b, input logic e, input logic err);
      bus_request       = req;
      begin_transaction = b;
      end_transaction   = e;
      bus_error         = err;
   endtask

   task automatic do_reset();
      drive(4'b0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0]  req;
      logic        b;
      logic        e;
      logic        err;
      logic [3:0]  g;
      logic [1:0]  id;
      logic        busy;
      logic        to;
      arb_state_e  st;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] req, input logic b, input logic e, input logic err,
                               input logic [3:0] g, input logic [1:0] id, input logic busy,
                               input logic to, input arb_state_e st);
      vec_t v;
      v.req = req; v.b = b; v.e = e; v.err = err;
      v.g = g; v.id = id; v.busy = busy; v.to = to; v.st = st;
      return v;
   endfunction

   vec_t vt[$];

   initial begin
      int  held;
      int  busy_cnt;
      int  wait_cnt;
      logic early_to;
      logic [ID_W-1:0] exp_id;

      // Each row: inputs driven for one cycle, outputs expected after the edge.
      vt.push_back(mk(4'b0001,0,0,0, 4'b0001,2'd0,1,0,ST_GRANTED)); // master 0 first
      vt.push_back(mk(4'b0001,0,1,0, 4'b0001,2'd0,1,0,ST_GRANTED)); // end ignored in GRANTED
      vt.push_back(mk(4'b0001,1,0,0, 4'b0001,2'd0,1,0,ST_BUSY));
      vt.push_back(mk(4'b0000,1,0,0, 4'b0001,2'd0,1,0,ST_BUSY));    // request drop, begin ignored
      vt.push_back(mk(4'b0000,0,0,0, 4'b0001,2'd0,1,0,ST_BUSY));
      vt.push_back(mk(4'b0000,0,1,0, 4'b0000,2'd0,1,0,ST_RELEASE));
      vt.push_back(mk(4'b0000,0,0,0, 4'b0000,2'd0,0,0,ST_IDLE));
      vt.push_back(mk(4'b1111,0,0,0, 4'b0010,2'd1,1,0,ST_GRANTED)); // rr moves to 1
      vt.push_back(mk(4'b1111,1,0,1, 4'b0000,2'd1,1,0,ST_RELEASE)); // error beats begin
      vt.push_back(mk(4'b1111,0,0,0, 4'b0000,2'd1,0,0,ST_IDLE));
      vt.push_back(mk(4'b1111,0,0,0, 4'b0100,2'd2,1,0,ST_GRANTED));
      vt.push_back(mk(4'b1011,0,0,0, 4'b0000,2'd2,1,0,ST_RELEASE)); // grantee withdrew
      vt.push_back(mk(4'b1011,0,0,0, 4'b0000,2'd2,0,0,ST_IDLE));
      vt.push_back(mk(4'b1011,0,0,0, 4'b1000,2'd3,1,0,ST_GRANTED));
      vt.push_back(mk(4'b1011,1,0,0, 4'b1000,2'd3,1,0,ST_BUSY));
      vt.push_back(mk(4'b1011,0,0,1, 4'b0000,2'd3,1,0,ST_RELEASE));
      vt.push_back(mk(4'b0000,0,0,0, 4'b0000,2'd3,0,0,ST_IDLE));
      vt.push_back(mk(4'b0000,0,0,0, 4'b0000,2'd3,0,0,ST_IDLE));
      vt.push_back(mk(4'b0110,0,0,0, 4'b0010,2'd1,1,0,ST_GRANTED)); // wrap from 3 skips 0
      vt.push_back(mk(4'b0110,1,1,0, 4'b0010,2'd1,1,0,ST_BUSY));
      vt.push_back(mk(4'b0110,0,1,1, 4'b0000,2'd1,1,0,ST_RELEASE));
      vt.push_back(mk(4'b0000,0,0,0, 4'b0000,2'd1,0,0,ST_IDLE));

      // ---- reset state ----
      reset = 1'b0;
      #2;
      chk("reset_outputs", {bus_grant, granted_id, arb_busy, timeout_error, state_dbg},
          {4'b0000, 2'd0, 1'b0, 1'b0, ST_IDLE});
      tick();
      reset = 1'b1;

      // ---- table ----
      foreach (vt[i]) begin
         drive(vt[i].req, vt[i].b, vt[i].e, vt[i].err);
         tick();
         chk($sformatf("vec%0d", i), {bus_grant, granted_id, arb_busy, timeout_error, state_dbg},
             {vt[i].g, vt[i].id, vt[i].busy, vt[i].to, vt[i].st});
      end

      // ---- round-robin with all masters requesting ----
      do_reset();
      for (int t = 0; t < 5; t++) exp_q.push_back(ID_W'(t % NUM_MASTERS));
      drive(4'b1111, 1'b0, 1'b0, 1'b0);
      for (int t = 0; t < 5; t++) begin
         wait_cnt = 0;
         tick();
         while (bus_grant == 4'b0000 && wait_cnt < 10) begin
            tick();
            wait_cnt++;
         end
         exp_id = exp_q.pop_front();
         chk($sformatf("rr_grant%0d", t), {bus_grant, granted_id},
             {id_to_onehot(exp_id), exp_id});
         begin_transaction = 1'b1;
         tick();
         begin_transaction = 1'b0;
         tick();
         end_transaction = 1'b1;
         tick();
         end_transaction = 1'b0;
      end

      // ---- grant timeout ----
      do_reset();
      drive(4'b0100, 1'b0, 1'b0, 1'b0);
      tick();
      held     = 0;
      early_to = 1'b0;
      while (bus_grant == 4'b0100 && held < 40) begin
         if (timeout_error) early_to = 1'b1;
         held++;
         tick();
      end
      chk("grant_hold_cycles", held, 16);
      chk("grant_no_early_to", early_to, 1'b0);
      chk("grant_to_pulse", {bus_grant, timeout_error, state_dbg}, {4'b0000, 1'b1, ST_RELEASE});
      bus_request = 4'b0000;
      tick();
      chk("grant_to_cleared", {bus_grant, timeout_error, state_dbg}, {4'b0000, 1'b0, ST_IDLE});

      // ---- watchdog timeout, next requester granted ----
      do_reset();
      drive(4'b0001, 1'b0, 1'b0, 1'b0);
      tick();
      chk("wd_grant0", {bus_grant, granted_id}, {4'b0001, 2'd0});
      drive(4'b0011, 1'b1, 1'b0, 1'b0);
      tick();
      begin_transaction = 1'b0;
      busy_cnt = 0;
      early_to = 1'b0;
      while (state_dbg == ST_BUSY && busy_cnt < 1100) begin
         if (timeout_error) early_to = 1'b1;
         busy_cnt++;
         tick();
      end
      chk("wd_busy_cycles", busy_cnt, 1024);
      chk("wd_no_early_to", early_to, 1'b0);
      chk("wd_to_pulse", {bus_grant, timeout_error, state_dbg}, {4'b0000, 1'b1, ST_RELEASE});
      tick();
      chk("wd_idle", {bus_grant, timeout_error, state_dbg}, {4'b0000, 1'b0, ST_IDLE});
      tick();
      chk("wd_next_grant", {bus_grant, granted_id}, {4'b0010, 2'd1});

      // ---- end coinciding with watchdog limit: normal release ----
      begin_transaction = 1'b1;
      tick();
      begin_transaction = 1'b0;
      repeat (1023) tick();
      chk("wd_edge_still_busy", {bus_grant, timeout_error, state_dbg}, {4'b0010, 1'b0, ST_BUSY});
      end_transaction = 1'b1;
      tick();
      end_transaction = 1'b0;
      chk("wd_edge_normal_end", {bus_grant, timeout_error, state_dbg}, {4'b0000, 1'b0, ST_RELEASE});
      bus_request = 4'b0000;
      tick();

      // ---- asynchronous reset in BUSY ----
      drive(4'b0100, 1'b0, 1'b0, 1'b0);
      tick();
      chk("ar_grant2", {bus_grant, granted_id}, {4'b0100, 2'd2});
      begin_transaction = 1'b1;
      tick();
      begin_transaction = 1'b0;
      bus_request = 4'b1111;
      #3;
      reset = 1'b0;
      #1;
      chk("ar_async_drop", {bus_grant, granted_id, arb_busy, timeout_error, state_dbg},
          {4'b0000, 2'd0, 1'b0, 1'b0, ST_IDLE});
      tick();
      chk("ar_held_in_reset", {bus_grant, timeout_error}, {4'b0000, 1'b0});
      reset = 1'b1;
      #2;
      chk("ar_no_grant_before_edge", bus_grant, 4'b0000);
      tick();
      chk("ar_last_id_reset", {bus_grant, granted_id}, {4'b0001, 2'd0});

      // ---- report ----
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
